// File: rtl/op_seq_pkg.sv
// Shared definitions for the op_sequencer: FSM state encoding and default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package op_seq_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int OP_W_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

endpackage

// File: rtl/op_sequencer.sv
// Sequences one ALU operation through IDLE->READ->EXEC->WB against an external regfile/ALU.
// Latency: done asserts in the third cycle after the accept edge; one op per 4 cycles.
// Backpressure: cmd_ready is high only in IDLE; overflow trap enabled by OP_SEQ_OVF_TRAP_EN.
module op_sequencer
  import op_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [ADDR_W-1:0] cmd_rt,
  input  logic [ADDR_W-1:0] cmd_rd,
  output logic [ADDR_W-1:0] R_Addr_A,
  output logic [ADDR_W-1:0] R_Addr_B,
  output logic [OP_W-1:0]   ALU_OP,
  input  logic [DATA_W-1:0] alu_F,
  input  logic              alu_ZF,
  input  logic              alu_OF,
  output logic              Write_Reg,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic              done,
  output logic              ZF,
  output logic              OF,
  output logic              err
);

  state_t            state;
  logic [ADDR_W-1:0] rd_q;

`ifdef OP_SEQ_OVF_TRAP_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Accept only while idle and out of reset, so a held cmd_valid is ignored mid-operation.
  assign cmd_ready = Reset && (state == IDLE);

  // FSM plus operand/result latches; write strobes are single-cycle and only leave EXEC->WB.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      rd_q      <= '0;
      R_Addr_A  <= '0;
      R_Addr_B  <= '0;
      ALU_OP    <= '0;
      Addr      <= '0;
      W_Data    <= '0;
      Write_Reg <= 1'b0;
      done      <= 1'b0;
      ZF        <= 1'b0;
      OF        <= 1'b0;
`ifdef OP_SEQ_OVF_TRAP_EN
      err_q     <= 1'b0;
`endif
    end else begin
      Write_Reg <= 1'b0;
      done      <= 1'b0;
`ifdef OP_SEQ_OVF_TRAP_EN
      err_q     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state    <= READ;
            R_Addr_A <= cmd_rs;
            R_Addr_B <= cmd_rt;
            ALU_OP   <= cmd_op;
            rd_q     <= cmd_rd;
          end
        end
        READ: begin
          state <= EXEC;
        end
        EXEC: begin
          // Capture the ALU result now; it is presented to the regfile during WB.
          state  <= WB;
          W_Data <= alu_F;
          ZF     <= alu_ZF;
          OF     <= alu_OF;
          Addr   <= rd_q;
          done   <= 1'b1;
`ifdef OP_SEQ_OVF_TRAP_EN
          // An overflowing result is trapped instead of committed.
          Write_Reg <= (rd_q != '0) && !alu_OF;
          err_q     <= alu_OF;
`else
          Write_Reg <= (rd_q != '0);
`endif
        end
        WB: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/op_sequencer.md
OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32: ALU operand/result width.
REQ-002 SHALL have parameter ADDR_W, default 5: register-file address width.
REQ-003 SHALL have parameter OP_W, default 3: ALU_OP width.
REQ-004 SHALL have one clock; reset SHALL be synchronous and active-low: Clk and Reset.
REQ-005 Clk  in  1  rising-edge clock.
REQ-006 Reset  in  1  synchronous active-low reset.
REQ-007 cmd_valid  in  1  command offered.
REQ-008 cmd_ready  out  1  sequencer accepts a command this cycle.
REQ-009 cmd_op  in  OP_W  ALU operation code.
REQ-010 cmd_rs, cmd_rt, cmd_rd  in  ADDR_W each  source A, source B, destination.
REQ-011 R_Addr_A, R_Addr_B  out  ADDR_W each  register-file read addresses.
REQ-012 ALU_OP  out  OP_W  operation to ALU.
REQ-013 alu_F  in  DATA_W  ALU result; alu_ZF, alu_OF  in  1 each  ALU flags.
REQ-014 Write_Reg  out  1  register-file write enable.
REQ-015 Addr  out  ADDR_W  write address; W_Data  out  DATA_W  write data.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 ZF, OF  out  1 each  flags of last completed operation.
REQ-018 err  out  1  one-cycle overflow-trap pulse (macro-dependent).

Function
REQ-019 FSM states SHALL be IDLE, READ, EXEC, WB, one transition per Clk edge.
REQ-020 cmd_ready SHALL be 1 only in IDLE; command accepted when cmd_valid & cmd_ready; IDLE->READ; fields latched.
REQ-021 IDLE with cmd_valid=0 SHALL stay IDLE; cmd_valid ignored in all other states.
REQ-022 READ: R_Addr_A=rs, R_Addr_B=rt, ALU_OP=op latched; READ->EXEC.
REQ-023 R_Addr_A/R_Addr_B/ALU_OP SHALL hold latched values through READ and EXEC.
REQ-024 EXEC: alu_F, alu_ZF, alu_OF SHALL be registered at end of cycle; EXEC->WB.
REQ-025 WB: Write_Reg=1 for exactly one cycle, Addr=rd, W_Data=registered F; done=1 same cycle; ZF/OF updated at WB edge; WB->IDLE.
REQ-026 rd==0 SHALL suppress Write_Reg (done, ZF, OF still updated).
REQ-027 Latency: acceptance edge to done = 3 cycles; back-to-back throughput one op per 4 cycles.
REQ-028 Write_Reg, done, err SHALL be 0 in every state other than WB.
REQ-029 rs/rt equal to rd of previous op SHALL read post-write value (write completes before next READ).

Reset
REQ-030 Reset=0 at a Clk edge SHALL force IDLE regardless of state, including mid-operation; pending write SHALL be dropped.
REQ-031 Reset values: cmd_ready=0 while Reset=0, then 1 in IDLE; R_Addr_A, R_Addr_B, Addr, ALU_OP=0; W_Data=0; Write_Reg, done, err, ZF, OF=0.

Configuration
REQ-032 Macro OP_SEQ_OVF_TRAP_EN defined: registered OF=1 in WB SHALL suppress Write_Reg and pulse err=1 with done=1; ZF/OF still updated.
REQ-033 Macro undefined: write-back SHALL ignore OF; err SHALL be tied 0.

Structure
REQ-034 Package op_seq_pkg SHALL hold state enum encoding (IDLE=0, READ=1, EXEC=2, WB=3) and default width constants.
REQ-035 Single module, no sub-module; FSM and datapath latches in one body.

Verification
REQ-036 Reset=0 for 2 cycles mid-EXEC -> next cycle IDLE, Write_Reg=0, all outputs at reset values, no done.
REQ-037 cmd op=ADD, rs=1 (5), rt=2 (7), rd=3 -> done 3 cycles after accept, Write_Reg=1, Addr=3, W_Data=12, ZF=0.
REQ-038 cmd op=SUB rs=rt=4 (value 9), rd=0 -> done, ZF=1, Write_Reg stays 0.
REQ-039 cmd_valid held high for 3 commands -> cmd_ready pulses every 4th cycle, exactly 3 done pulses, second op reads first op's result.
REQ-040 ADD 0x7FFFFFFF+1, rd=5: macro defined -> err=1, no write, OF=1; undefined -> Write_Reg=1, W_Data=0x80000000, OF=1, err=0.
